// File: rtl/matmul_mem_pkg.sv
// Shared widths and word types for the matmul load-side memories.
package matmul_mem_pkg;

  localparam int MM_ADDR_W = 4;
  localparam int MM_DATA_W = 32;

  typedef logic [MM_ADDR_W-1:0] mm_addr_t;
  typedef logic [MM_DATA_W-1:0] mm_word_t;

endpackage

// File: rtl/ld_out_fifo.sv
// Registered output queue for the load server; depth need not be a power of two.
module ld_out_fifo #(
  parameter int DATA_W    = 32,
  parameter int OUT_DEPTH = 3,
  localparam int PW       = $clog2(OUT_DEPTH),
  localparam int CW       = $clog2(OUT_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CW-1:0]     cnt_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] slot_q [OUT_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
    else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) slot_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = slot_q[rd_ptr_q];
  assign cnt_o   = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/matmul_ld_mem.sv
// Host-preloaded register-file load server for one matmul operand port.
module matmul_ld_mem
  import matmul_mem_pkg::*;
#(
  parameter int ADDR_W    = MM_ADDR_W,
  parameter int DATA_W    = MM_DATA_W,
  parameter int OUT_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_addr_valid,
  output logic              ld_addr_ready,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_data_valid,
  input  logic              ld_data_ready,
  output logic [15:0]       served_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = $clog2(OUT_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word_q;
  logic              pend_q, pend_d;
  logic [15:0]       served_q, served_d;
  logic [CW-1:0]     cnt;
  logic              q_empty;
  logic [CW:0]       inflight;
  logic              addr_fire, data_fire;

  // Ready looks only at registered occupancy plus the in-flight read, so a
  // slot is always reserved for every accepted address.
  assign inflight      = {1'b0, cnt} + {{CW{1'b0}}, pend_q};
  assign ld_addr_ready = !reset && (inflight < (CW + 1)'(OUT_DEPTH));
  assign ld_data_valid = !reset && !q_empty;
  assign addr_fire     = ld_addr_valid && ld_addr_ready;
  assign data_fire     = ld_data_valid && ld_data_ready;
  assign served_count  = served_q;

  always_comb begin
    pend_d   = addr_fire;
    served_d = served_q;
    if (data_fire) served_d = served_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q   <= 1'b0;
      served_q <= '0;
    end else begin
      pend_q   <= pend_d;
      served_q <= served_d;
    end
  end

  always_ff @(posedge clock) begin
    if (host_wr_en && !reset) mem_q[host_wr_addr] <= host_wr_data;
  end

  // Read stage: nonblocking read gives the pre-write word on a same-cycle collision.
  always_ff @(posedge clock) begin
    if (addr_fire) rd_word_q <= mem_q[ld_addr];
  end

  ld_out_fifo #(
    .DATA_W    (DATA_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (pend_q),
    .push_data_i (rd_word_q),
    .pop_i       (data_fire),
    .head_o      (ld_data),
    .cnt_o       (cnt),
    .empty_o     (q_empty)
  );

endmodule

// File: tb/tb_matmul_ld_mem.sv
// Randomised self-checking bench for matmul_ld_mem against a queue-based memory model.
module tb_matmul_ld_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        host_wr_en = 1'b0;
  logic [3:0]  host_wr_addr = '0;
  logic [31:0] host_wr_data = '0;
  logic [3:0]  ld_addr = '0;
  logic        ld_addr_valid = 1'b0;
  logic        ld_addr_ready;
  logic [31:0] ld_data;
  logic        ld_data_valid;
  logic        ld_data_ready = 1'b0;
  logic [15:0] served_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic [31:0] want_q [$];
  logic [15:0] model_served = '0;
  int unsigned n_acc = 0;

  matmul_ld_mem dut (
    .clock         (clock),
    .reset         (reset),
    .host_wr_en    (host_wr_en),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .ld_addr       (ld_addr),
    .ld_addr_valid (ld_addr_valid),
    .ld_addr_ready (ld_addr_ready),
    .ld_data       (ld_data),
    .ld_data_valid (ld_data_valid),
    .ld_data_ready (ld_data_ready),
    .served_count  (served_count)
  );

  always #5 clock = ~clock;

  // Inputs change just after posedge, so the falling edge sees what the next rising edge will.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      model_served = '0;
    end else begin
      if (ld_addr_valid && ld_addr_ready) begin
        exp_q.push_back(ref_mem[ld_addr]);
        n_acc++;
      end
      if (host_wr_en) ref_mem[host_wr_addr] = host_wr_data;
      if (ld_data_valid && ld_data_ready) begin
        got_q.push_back(ld_data);
        if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
        else want_q.push_back('x);
        model_served = model_served + 16'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    host_wr_en   = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic drain(input int target, input int budget);
    int k;
    k = 0;
    ld_data_ready = 1'b1;
    while (got_q.size() < target && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (got_q.size() < target) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words, required %0d", got_q.size(), target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clock);
    checks += 3;
    if (ld_addr_ready !== 1'b0) begin errors++; $display("FAIL rst_addr_ready: got %b required 0", ld_addr_ready); end
    if (ld_data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid: got %b required 0", ld_data_valid); end
    if (served_count !== 16'h0) begin errors++; $display("FAIL rst_served: got %h required 0000", served_count); end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks += 2;
    if (ld_addr_ready !== 1'b1) begin errors++; $display("FAIL rst_exit_ready: got %b required 1", ld_addr_ready); end
    if (ld_data_valid !== 1'b0) begin errors++; $display("FAIL rst_exit_valid: got %b required 0", ld_data_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned a0;
    int b0;
    for (int i = 0; i < 16; i++) host_write(4'(i), 32'h100 + 32'(i));
    a0 = n_acc;
    b0 = got_q.size();
    ld_data_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ld_addr       = 4'(i);
      ld_addr_valid = 1'b1;
      tick();
    end
    ld_addr_valid = 1'b0;
    checks++;
    if (n_acc - a0 != 16) begin errors++; $display("FAIL b2b_accepts: got %0d required 16", n_acc - a0); end
    drain(b0 + 16, 20);
    for (int i = 0; i < 16 && b0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[b0+i] !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h required %h", i, got_q[b0+i], 32'h100 + 32'(i));
      end
    end
    @(negedge clock);
    checks++;
    if (served_count !== 16'd16) begin errors++; $display("FAIL b2b_served: got %0d required 16", served_count); end
    tick();
  endtask

  task automatic test_backpressure();
    int list [4];
    int idx;
    int unsigned a0;
    int b0;
    logic fire;
    list = '{3, 4, 5, 6};
    idx = 0;
    a0 = n_acc;
    b0 = got_q.size();
    ld_data_ready = 1'b0;
    ld_addr       = 4'(list[0]);
    ld_addr_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      fire = ld_addr_ready;
      tick();
      if (fire && idx < 3) begin
        idx++;
        ld_addr = 4'(list[idx]);
      end
    end
    checks++;
    if (n_acc - a0 != 3) begin errors++; $display("FAIL bp_accepts: got %0d required 3", n_acc - a0); end
    @(negedge clock);
    checks++;
    if (ld_addr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b required 0", ld_addr_ready); end
    tick();
    ld_data_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (ld_addr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_at_pop: got %b required 0", ld_addr_ready); end
    tick();
    @(negedge clock);
    checks++;
    if (ld_addr_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b required 1", ld_addr_ready); end
    tick();
    ld_addr_valid = 1'b0;
    checks++;
    if (n_acc - a0 != 4) begin errors++; $display("FAIL bp_addr6_accept: got %0d accepts required 4", n_acc - a0); end
    drain(b0 + 4, 10);
    for (int i = 0; i < 4 && b0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[b0+i] !== 32'h103 + 32'(i)) begin
        errors++;
        $display("FAIL bp_data[%0d]: got %h required %h", i, got_q[b0+i], 32'h103 + 32'(i));
      end
    end
    tick();
  endtask

  task automatic test_collision();
    int b0;
    host_write(4'd7, 32'hAAAA_AAAA);
    b0 = got_q.size();
    ld_data_ready = 1'b1;
    host_wr_en    = 1'b1;
    host_wr_addr  = 4'd7;
    host_wr_data  = 32'h5555_5555;
    ld_addr       = 4'd7;
    ld_addr_valid = 1'b1;
    tick();
    host_wr_en    = 1'b0;
    ld_addr_valid = 1'b0;
    drain(b0 + 1, 8);
    ld_addr_valid = 1'b1;
    tick();
    ld_addr_valid = 1'b0;
    drain(b0 + 2, 8);
    if (got_q.size() >= b0 + 2) begin
      checks += 2;
      if (got_q[b0] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL coll_old: got %h required aaaaaaaa", got_q[b0]); end
      if (got_q[b0+1] !== 32'h5555_5555) begin errors++; $display("FAIL coll_new: got %h required 55555555", got_q[b0+1]); end
    end
    tick();
  endtask

  task automatic test_stall();
    logic [3:0]  a;
    logic [31:0] expw, hold;
    logic [15:0] s0;
    int b0, k;
    a    = 4'(8 + $urandom_range(0, 7));
    expw = ref_mem[a];
    b0   = got_q.size();
    ld_data_ready = 1'b0;
    ld_addr       = a;
    ld_addr_valid = 1'b1;
    tick();
    ld_addr_valid = 1'b0;
    k = 0;
    @(negedge clock);
    while (!ld_data_valid && k < 5) begin
      tick();
      @(negedge clock);
      k++;
    end
    hold = ld_data;
    s0   = served_count;
    checks++;
    if (ld_data_valid !== 1'b1 || ld_data !== expw) begin
      errors++;
      $display("FAIL stall_head: got %h/%b required %h/1", ld_data, ld_data_valid, expw);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      host_wr_en   = 1'b1;
      host_wr_addr = a;
      host_wr_data = $urandom;
      @(negedge clock);
      checks++;
      if (ld_data !== hold || ld_data_valid !== 1'b1 || served_count !== s0) begin
        errors++;
        $display("FAIL stall_stable[%0d]: got %h/%b/%0d required %h/1/%0d",
                 c, ld_data, ld_data_valid, served_count, hold, s0);
      end
    end
    tick();
    host_wr_en = 1'b0;
    drain(b0 + 1, 5);
    if (got_q.size() > b0) begin
      checks++;
      if (got_q[b0] !== expw) begin errors++; $display("FAIL stall_pop: got %h required %h", got_q[b0], expw); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int unsigned a0;
    int b0;
    a0 = n_acc;
    ld_data_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ld_addr       = 4'(i);
      ld_addr_valid = 1'b1;
      tick();
    end
    ld_addr_valid = 1'b0;
    checks++;
    if (n_acc - a0 != 3) begin errors++; $display("FAIL rmid_accepts: got %0d required 3", n_acc - a0); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (ld_data_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_in_reset: got %b required 0", ld_data_valid); end
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks += 3;
    if (ld_data_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b required 0", ld_data_valid); end
    if (served_count !== 16'h0) begin errors++; $display("FAIL rmid_served: got %h required 0000", served_count); end
    if (ld_addr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b required 1", ld_addr_ready); end
    b0 = got_q.size();
    tick();
    ld_data_ready = 1'b1;
    ld_addr       = 4'd0;
    ld_addr_valid = 1'b1;
    tick();
    ld_addr_valid = 1'b0;
    drain(b0 + 1, 6);
    tick();
    tick();
    checks += 2;
    if (got_q.size() != b0 + 1) begin errors++; $display("FAIL rmid_words: got %0d required 1", got_q.size() - b0); end
    if (got_q.size() > b0 && got_q[b0] !== 32'h100) begin
      errors++;
      $display("FAIL rmid_load0: got %h required 00000100", got_q[b0]);
    end
  endtask

  task automatic test_random();
    int b0;
    b0 = got_q.size();
    for (int c = 0; c < 400; c++) begin
      ld_addr_valid = ($urandom_range(0, 3) != 0);
      ld_addr       = 4'($urandom);
      ld_data_ready = ($urandom_range(0, 2) != 0);
      host_wr_en    = ($urandom_range(0, 3) == 0);
      host_wr_addr  = 4'($urandom);
      host_wr_data  = $urandom;
      tick();
    end
    ld_addr_valid = 1'b0;
    host_wr_en    = 1'b0;
    tick();
    drain(got_q.size() + exp_q.size(), 20);
    for (int i = b0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin
        errors++;
        $display("FAIL rand_data[%0d]: got %h required %h", i - b0, got_q[i], want_q[i]);
      end
    end
    @(negedge clock);
    checks++;
    if (served_count !== model_served) begin
      errors++;
      $display("FAIL rand_served: got %0d required %0d", served_count, model_served);
    end
    tick();
  endtask

  task automatic test_wrap();
    int unsigned a0;
    int k;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a0 = n_acc;
    ld_data_ready = 1'b1;
    ld_addr_valid = 1'b1;
    k = 0;
    while (n_acc - a0 < 65535 && k < 70000) begin
      ld_addr = 4'($urandom);
      tick();
      k++;
    end
    ld_addr_valid = 1'b0;
    k = 0;
    @(negedge clock);
    while (served_count !== 16'hFFFF && k < 10) begin
      tick();
      @(negedge clock);
      k++;
    end
    checks++;
    if (served_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset: got %h required ffff", served_count); end
    tick();
    ld_addr       = 4'd1;
    ld_addr_valid = 1'b1;
    tick();
    ld_addr_valid = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clock);
    checks += 2;
    if (served_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h required 0000", served_count); end
    if (served_count !== model_served) begin errors++; $display("FAIL wrap_model: got %h required %h", served_count, model_served); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_collision();
    test_stall();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
